// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI FT60x transmit arbiter: defaults,
// FSM state encoding and header field layout.
package ftdi_pkg;

  localparam int         PACKET_SIZE_DEF = 1024;
  localparam logic [7:0] HDR_MAGIC_DEF   = 8'hA5;

  // Header word layout: {magic[31:24], src[23:20], 4'h0, seq[15:0]}
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_SRC_LSB   = 20;
  localparam int HDR_SEQ_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [31:0] make_header(input logic [7:0]  magic,
                                              input logic [3:0]  src,
                                              input logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 8] = magic;
    w[HDR_SRC_LSB   +: 4] = src;
    w[HDR_SEQ_LSB   +: 16] = seq;
    return w;
  endfunction

endpackage

// File: rtl/ftdi_skid_fifo.sv
// Two-entry, 32-bit FIFO that absorbs FTDI backpressure. Entries leave in
// strict push order; head is combinational from storage.
module ftdi_skid_fifo
  import ftdi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        do_push;
  logic        do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves the same edge.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the FT60x write channel between
// NUM_SRC source FIFOs. Each grant emits one header word followed by
// PACKET_SIZE data words from the granted source.
//
// Handshakes: src_rd_en[i] high at an edge requests one word; the source
// answers with src_valid[i] and its data during the following cycle.
// On the bus, a word moves when ftdi_wr_n and ftdi_txe_n are both low at a
// rising edge; otherwise ftdi_data holds.
module ftdi_tx_arbiter
  import ftdi_pkg::*;
#(
  parameter int         NUM_SRC     = 4,
  parameter int         PACKET_SIZE = PACKET_SIZE_DEF,
  parameter logic [7:0] HDR_MAGIC   = HDR_MAGIC_DEF
) (
  input  logic                    ftdi_clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_SRC-1:0]      src_pkt_rdy,
  output logic [NUM_SRC-1:0]      src_rd_en,
  input  logic [32*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic                    ftdi_txe_n,
  output logic [31:0]             ftdi_data,
  output logic [3:0]              ftdi_be,
  output logic                    ftdi_wr_n,
  output logic                    busy,
  output logic [3:0]              grant_idx,
  output logic                    err_underflow
);

  localparam int            CW      = $clog2(PACKET_SIZE + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(PACKET_SIZE - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    rr_ptr;
  logic [CW-1:0] rd_cnt;
  logic [15:0]   seq [NUM_SRC];
  logic          inflight;

  logic          found;
  logic [3:0]    pick;
  logic          valid_sel;
  logic [31:0]   data_sel;
  logic [15:0]   seq_sel;

  logic          grant_load;
  logic          hdr_push;
  logic          rd_issue;
  logic          space;
  logic [2:0]    occ;

  logic          skid_push;
  logic [31:0]   skid_push_data;
  logic          skid_drain;
  logic [31:0]   skid_head;
  logic          skid_full;
  logic          skid_empty;
  logic [1:0]    skid_count;

  ftdi_skid_fifo u_skid (
    .clk       (ftdi_clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .push_data (skid_push_data),
    .pop       (skid_drain),
    .head      (skid_head),
    .full      (skid_full),
    .empty     (skid_empty),
    .count     (skid_count)
  );

  assign ftdi_data  = skid_head;
  assign ftdi_wr_n  = skid_empty;
  assign ftdi_be    = 4'b1111;
  assign busy       = (state != ST_IDLE) || !skid_empty;
  assign skid_drain = !skid_empty && !ftdi_txe_n;

  // Room for one more word once every outstanding read has landed:
  // occupancy + in-flight - draining < 2.
  assign occ   = {1'b0, skid_count} + {2'b00, inflight};
  assign space = skid_drain ? !(skid_full && inflight) : (occ < 3'd2);

  // Round-robin pick: first ready source strictly after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && src_pkt_rdy[i] && (((int'(rr_ptr) + k) % NUM_SRC) == i)) begin
          found = 1'b1;
          pick  = 4'(i);
        end
      end
    end
  end

  // Select the granted source's valid, data, sequence number and read strobe.
  always_comb begin
    valid_sel = 1'b0;
    data_sel  = '0;
    seq_sel   = '0;
    src_rd_en = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == 4'(i)) begin
        valid_sel    = src_valid[i];
        data_sel     = src_data[32*i +: 32];
        seq_sel      = seq[i];
        src_rd_en[i] = rd_issue;
      end
    end
  end

  // Skid input: the header in HDR, otherwise whatever word lands from the source.
  assign skid_push      = hdr_push || valid_sel;
  assign skid_push_data = hdr_push ? make_header(HDR_MAGIC, grant_idx, seq_sel) : data_sel;

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    hdr_push   = 1'b0;
    rd_issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && found) begin
          grant_load = 1'b1;
          state_nxt  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (space) begin
          hdr_push  = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (space) begin
          rd_issue = 1'b1;
          if (rd_cnt == LAST_RD) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, grant bookkeeping and read counting.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= 4'(NUM_SRC - 1);
      grant_idx <= 4'd0;
      rd_cnt    <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_issue;
      if (grant_load) begin
        grant_idx <= pick;
        rr_ptr    <= pick;
      end
      if (hdr_push) begin
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  // Per-source packet sequence numbers, bumped as each header is queued.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        seq[i] <= '0;
      end
    end else if (hdr_push) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_idx == 4'(i)) begin
          seq[i] <= seq[i] + 16'd1;
        end
      end
    end
  end

  // Sticky flag: a read whose data never arrived the following cycle.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (inflight && !valid_sel) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: reactive source FIFO models, an expected-word
// queue filled as each packet is requested, and a bus monitor that pops and
// compares every accepted word.
module tb_ftdi_tx_arbiter;

  localparam int NUM_SRC     = 4;
  localparam int PACKET_SIZE = 1024;
  localparam int HALF        = 5;
  localparam int T2_BOUND    = 8 * (PACKET_SIZE + 4) + 4;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [NUM_SRC-1:0]    src_pkt_rdy;
  logic [NUM_SRC-1:0]    src_rd_en;
  logic [32*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic                  ftdi_txe_n;
  logic [31:0]           ftdi_data;
  logic [3:0]            ftdi_be;
  logic                  ftdi_wr_n;
  logic                  busy;
  logic [3:0]            grant_idx;
  logic                  err_underflow;

  ftdi_tx_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .PACKET_SIZE (PACKET_SIZE),
    .HDR_MAGIC   (8'hA5)
  ) dut (
    .ftdi_clk      (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .src_pkt_rdy   (src_pkt_rdy),
    .src_rd_en     (src_rd_en),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .ftdi_txe_n    (ftdi_txe_n),
    .ftdi_data     (ftdi_data),
    .ftdi_be       (ftdi_be),
    .ftdi_wr_n     (ftdi_wr_n),
    .busy          (busy),
    .grant_idx     (grant_idx),
    .err_underflow (err_underflow)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  int          acc_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_ctr [NUM_SRC];
  logic [31:0] exp_ctr   [NUM_SRC];
  int          withhold_src = -1;
  int          withhold_cnt = 0;
  logic [NUM_SRC-1:0] rd_mask;

  function automatic logic [31:0] src_word(input int s, input logic [31:0] n);
    return {4'(s), 4'hD, n[23:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_packet(input int s, input logic [31:0] header, input int nwords);
    exp_q.push_back(header);
    for (int n = 0; n < nwords; n++) begin
      exp_q.push_back(src_word(s, exp_ctr[s]));
      exp_ctr[s] = exp_ctr[s] + 32'd1;
    end
  endtask

  // ---------------- source FIFO models ----------------
  initial begin
    src_valid = '0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      rd_mask = src_rd_en;
      @(posedge clk);
      #1;
      src_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rd_mask[i]) begin
          if (i == withhold_src && withhold_cnt == 1) begin
            withhold_src = -1;
            withhold_cnt = 0;
          end else begin
            if (i == withhold_src) withhold_cnt--;
            src_valid[i]          = 1'b1;
            src_data[32*i +: 32]  = src_word(i, model_ctr[i]);
            model_ctr[i]          = model_ctr[i] + 32'd1;
          end
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n && !ftdi_wr_n && !ftdi_txe_n) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none at %0t", ftdi_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check32("stream", ftdi_data, exp_w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_SRC; i++) begin
      model_ctr[i] = '0;
      exp_ctr[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic raise_rdy(input logic [NUM_SRC-1:0] m);
    @(posedge clk);
    #1;
    src_pkt_rdy = m;
  endtask

  task automatic wait_hdr(input int n_data);
    int n = 0;
    while (exp_q.size() > n_data && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL header_timeout: got %0d queued words expected <= %0d", exp_q.size(), n_data);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] t2_hdr [8];
    int n;
    int low_cycles;

    rst_n       = 1'b0;
    enable      = 1'b1;
    src_pkt_rdy = '0;
    ftdi_txe_n  = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check32("reset_wr_n",  32'(ftdi_wr_n),     32'd1);
    check32("reset_data",  ftdi_data,          32'h0);
    check32("reset_rd_en", 32'(src_rd_en),     32'h0);
    check32("reset_busy",  32'(busy),          32'd0);
    check32("reset_grant", 32'(grant_idx),     32'd0);
    check32("reset_err",   32'(err_underflow), 32'd0);
    check32("be_const",    32'(ftdi_be),       32'hF);

    // Only source 2 ready: header A5200000 after two cycles, then its data
    expect_packet(2, 32'hA5200000, PACKET_SIZE);
    raise_rdy(4'b0100);
    @(negedge clk);
    @(negedge clk);
    check32("lat_cycle1_wr_n", 32'(ftdi_wr_n), 32'd1);
    @(negedge clk);
    check32("lat_cycle2_wr_n", 32'(ftdi_wr_n), 32'd0);
    check32("lat_cycle2_grant", 32'(grant_idx), 32'd2);
    wait_hdr(PACKET_SIZE);
    src_pkt_rdy = '0;
    wait_drain(3000);

    // All four ready for eight packets: order 0,1,2,3,0,1,2,3
    do_reset();
    t2_hdr = '{32'hA5000000, 32'hA5100000, 32'hA5200000, 32'hA5300000,
               32'hA5000001, 32'hA5100001, 32'hA5200001, 32'hA5300001};
    for (int p = 0; p < 8; p++) begin
      expect_packet(p % NUM_SRC, t2_hdr[p], PACKET_SIZE);
    end
    raise_rdy(4'b1111);
    n = 0;
    while (exp_q.size() > PACKET_SIZE && n < 9000) begin
      @(negedge clk);
      n++;
    end
    src_pkt_rdy = '0;
    while ((exp_q.size() != 0 || busy) && n < 9000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n > T2_BOUND) begin
      errors++;
      $display("FAIL t2_cycles: got %0d cycles required <= %0d", n, T2_BOUND);
    end

    // Backpressure: 5-cycle stall mid-packet, then ~30% random stalls
    acc_cnt = 0;
    expect_packet(0, 32'hA5000002, PACKET_SIZE);
    raise_rdy(4'b0001);
    wait_hdr(PACKET_SIZE);
    src_pkt_rdy = '0;
    n = 0;
    while (exp_q.size() >= 600 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    ftdi_txe_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32("stall_hold", ftdi_data, exp_q[0]);
      check32("stall_wr_n", 32'(ftdi_wr_n), 32'd0);
      if (k >= 1) check32("stall_rd_en", 32'(src_rd_en), 32'h0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge clk);
      #1;
      ftdi_txe_n = ($urandom_range(0, 99) < 30);
      n++;
    end
    @(posedge clk);
    #1;
    ftdi_txe_n = 1'b0;
    wait_drain(3000);
    repeat (5) @(negedge clk);
    check32("t3_word_count", 32'(acc_cnt), 32'(PACKET_SIZE + 1));

    // Enable dropped during DATA: packet completes, nothing new until re-enable
    expect_packet(1, 32'hA5100002, PACKET_SIZE);
    raise_rdy(4'b0010);
    wait_hdr(PACKET_SIZE);
    enable = 1'b0;
    wait_drain(3000);
    low_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ftdi_wr_n || busy) low_cycles++;
    end
    check32("disabled_idle_cycles", 32'(low_cycles), 32'd0);
    expect_packet(1, 32'hA5100003, PACKET_SIZE);
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_hdr(PACKET_SIZE);
    src_pkt_rdy = '0;
    wait_drain(3000);

    // Withheld src_valid: short packet, sticky error, next packet normal
    check32("err_before", 32'(err_underflow), 32'd0);
    withhold_src = 3;
    withhold_cnt = 10;
    expect_packet(3, 32'hA5300002, PACKET_SIZE - 1);
    raise_rdy(4'b1000);
    wait_hdr(PACKET_SIZE - 1);
    src_pkt_rdy = '0;
    wait_drain(3000);
    check32("err_set", 32'(err_underflow), 32'd1);
    expect_packet(2, 32'hA5200002, PACKET_SIZE);
    raise_rdy(4'b0100);
    wait_hdr(PACKET_SIZE);
    src_pkt_rdy = '0;
    wait_drain(3000);
    check32("err_sticky", 32'(err_underflow), 32'd1);

    // Asynchronous reset in DATA, then a fresh packet from source 0 with seq 0
    expect_packet(0, 32'hA5000003, PACKET_SIZE);
    raise_rdy(4'b0001);
    wait_hdr(PACKET_SIZE);
    n = 0;
    while (exp_q.size() >= 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check32("async_rst_wr_n",  32'(ftdi_wr_n),     32'd1);
    check32("async_rst_rd_en", 32'(src_rd_en),     32'h0);
    check32("async_rst_busy",  32'(busy),          32'd0);
    check32("async_rst_err",   32'(err_underflow), 32'd0);
    check32("async_rst_grant", 32'(grant_idx),     32'd0);
    do_reset();
    expect_packet(0, 32'hA5000000, PACKET_SIZE);
    wait_hdr(PACKET_SIZE);
    src_pkt_rdy = '0;
    wait_drain(3000);
    check32("post_rst_grant", 32'(grant_idx), 32'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
